// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle, owns the minimal CSR
// file, and turns SYSCALL/ERTN into a fetch redirect plus pipeline flush.
module wb_stage #(
  parameter int MS_TO_WS_BUS_WD = 152,
  parameter int WS_FWD_BUS_WD   = 38
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [WS_FWD_BUS_WD-1:0]   ws_fwd_bus,
  output logic                       ws_flush_pipe,
  output logic [31:0]                ws_flush_pc,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_we,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;

  // Implemented-bit masks; unimplemented bits are never written so they read 0.
  localparam logic [31:0] CRMD_IMPL   = 32'h0000_000F;
  localparam logic [31:0] PRMD_IMPL   = 32'h0000_0007;
  localparam logic [31:0] ESTAT_IMPL  = 32'h7FFF_0000;
  localparam logic [31:0] EENTRY_IMPL = 32'hFFFF_FFC0;
  localparam logic [31:0] FULL_IMPL   = 32'hFFFF_FFFF;

  localparam logic [5:0] ECODE_SYS = 6'h0B;

  logic                       ws_valid_q;
  logic [MS_TO_WS_BUS_WD-1:0] bus_q;

  logic [31:0] csr_wvalue;
  logic        ertn;
  logic        syscall;
  logic        csr_re;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] final_result;
  logic [31:0] pc;

  assign {csr_wvalue, ertn, syscall, csr_re, csr_we, csr_num,
          csr_wmask, gr_we, dest, final_result, pc} = bus_q;

  logic [31:0] crmd_q,  crmd_d;
  logic [31:0] prmd_q,  prmd_d;
  logic [31:0] estat_q, estat_d;
  logic [31:0] era_q,   era_d;
  logic [31:0] eentry_q, eentry_d;
  logic [31:0] save0_q, save0_d;
  logic [31:0] save1_q, save1_d;
  logic [31:0] save2_q, save2_d;
  logic [31:0] save3_q, save3_d;
  logic [31:0] csr_rvalue;

  logic do_syscall;
  logic do_ertn;
  logic do_csrwr;

  assign ws_allowin = 1'b1;  // !ws_valid | ws_ready_go with ws_ready_go tied high
  assign do_syscall = ws_valid_q & syscall;
  assign do_ertn    = ws_valid_q & ertn;
  assign do_csrwr   = ws_valid_q & csr_we;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                            input logic [31:0] wv,
                                            input logic [31:0] wm,
                                            input logic [31:0] impl);
    logic [31:0] m;
    m = wm & impl;
    return (old_v & ~m) | (wv & m);
  endfunction

  // Stage valid bit: accepts a new instruction whenever allowin is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid_q <= ms_to_ws_valid;
    end
  end

  // Payload register: only captured for a real incoming instruction.
  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) begin
      bus_q <= ms_to_ws_bus;
    end
  end

  // CSR read mux: returns the current (pre-write) value.
  always_comb begin
    csr_rvalue = '0;
    unique case (csr_num)
      CSR_CRMD:   csr_rvalue = crmd_q;
      CSR_PRMD:   csr_rvalue = prmd_q;
      CSR_ESTAT:  csr_rvalue = estat_q;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_EENTRY: csr_rvalue = eentry_q;
      CSR_SAVE0:  csr_rvalue = save0_q;
      CSR_SAVE1:  csr_rvalue = save1_q;
      CSR_SAVE2:  csr_rvalue = save2_q;
      CSR_SAVE3:  csr_rvalue = save3_q;
      default:    csr_rvalue = '0;
    endcase
  end

  // CSR next state: software write first, then exception/return updates
  // overwrite the fields they own so they win on overlap.
  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    estat_d  = estat_q;
    era_d    = era_q;
    eentry_d = eentry_q;
    save0_d  = save0_q;
    save1_d  = save1_q;
    save2_d  = save2_q;
    save3_d  = save3_q;
    if (do_csrwr) begin
      unique case (csr_num)
        CSR_CRMD:   crmd_d   = csr_merge(crmd_q,   csr_wvalue, csr_wmask, CRMD_IMPL);
        CSR_PRMD:   prmd_d   = csr_merge(prmd_q,   csr_wvalue, csr_wmask, PRMD_IMPL);
        CSR_ESTAT:  estat_d  = csr_merge(estat_q,  csr_wvalue, csr_wmask, ESTAT_IMPL);
        CSR_ERA:    era_d    = csr_merge(era_q,    csr_wvalue, csr_wmask, FULL_IMPL);
        CSR_EENTRY: eentry_d = csr_merge(eentry_q, csr_wvalue, csr_wmask, EENTRY_IMPL);
        CSR_SAVE0:  save0_d  = csr_merge(save0_q,  csr_wvalue, csr_wmask, FULL_IMPL);
        CSR_SAVE1:  save1_d  = csr_merge(save1_q,  csr_wvalue, csr_wmask, FULL_IMPL);
        CSR_SAVE2:  save2_d  = csr_merge(save2_q,  csr_wvalue, csr_wmask, FULL_IMPL);
        CSR_SAVE3:  save3_d  = csr_merge(save3_q,  csr_wvalue, csr_wmask, FULL_IMPL);
        default: ;
      endcase
    end
    if (do_syscall) begin
      prmd_d[2:0]   = crmd_q[2:0];
      crmd_d[2:0]   = 3'b000;
      era_d         = pc;
      estat_d[21:16] = ECODE_SYS;
      estat_d[30:22] = '0;
    end else if (do_ertn) begin
      crmd_d[2:0]   = prmd_q[2:0];
    end
  end

  // CSR state registers with architectural reset values.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q   <= 32'h0000_0008;
      prmd_q   <= '0;
      estat_q  <= '0;
      era_q    <= '0;
      eentry_q <= '0;
      save0_q  <= '0;
      save1_q  <= '0;
      save2_q  <= '0;
      save3_q  <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      eentry_q <= eentry_d;
      save0_q  <= save0_d;
      save1_q  <= save1_d;
      save2_q  <= save2_d;
      save3_q  <= save3_d;
    end
  end

  assign rf_we    = ws_valid_q & gr_we & ~syscall & ~ertn;
  assign rf_waddr = dest;
  assign rf_wdata = csr_re ? csr_rvalue : final_result;

  assign ws_fwd_bus = {rf_we, dest, rf_wdata};

  assign ws_flush_pipe = do_syscall | do_ertn;
  assign ws_flush_pc   = do_syscall ? eentry_q : era_q;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: each driven cycle queues the outputs expected
// one cycle later; they are popped and compared on the following negedge.
module tb_wb_stage;

  logic         clk;
  logic         reset;
  logic         ms_to_ws_valid;
  logic [151:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [37:0]  ws_fwd_bus;
  logic         ws_flush_pipe;
  logic [31:0]  ws_flush_pc;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_we;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  wb_stage #(.MS_TO_WS_BUS_WD(152), .WS_FWD_BUS_WD(38)) dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_bus        (ws_fwd_bus),
    .ws_flush_pipe     (ws_flush_pipe),
    .ws_flush_pc       (ws_flush_pc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          fl;
    logic [31:0] fpc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [151:0] mk(input logic [31:0] wv, input logic er, input logic sc,
                                      input logic re, input logic we, input logic [13:0] num,
                                      input logic [31:0] mask, input logic gwe,
                                      input logic [4:0] d, input logic [31:0] res,
                                      input logic [31:0] pc);
    return {wv, er, sc, re, we, num, mask, gwe, d, res, pc};
  endfunction

  function automatic exp_t ex(input bit v, input bit we, input logic [4:0] wa,
                              input logic [31:0] wd, input bit fl, input logic [31:0] fpc,
                              input logic [31:0] pc);
    exp_t e;
    e.v = v; e.we = we; e.wa = wa; e.wd = wd; e.fl = fl; e.fpc = fpc; e.pc = pc;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    check("allowin", 32'(ws_allowin), 32'd1);
    check("rf_we", 32'(rf_we), 32'(e.we));
    check("fwd_valid", 32'(ws_fwd_bus[37]), 32'(e.we));
    check("dbg_rf_we", 32'(debug_wb_rf_we), {28'd0, {4{e.we}}});
    check("flush", 32'(ws_flush_pipe), 32'(e.fl));
    if (e.we) begin
      check("rf_waddr", 32'(rf_waddr), 32'(e.wa));
      check("rf_wdata", rf_wdata, e.wd);
      check("fwd_dest", 32'(ws_fwd_bus[36:32]), 32'(e.wa));
      check("fwd_data", ws_fwd_bus[31:0], e.wd);
      check("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(e.wa));
      check("dbg_wdata", debug_wb_rf_wdata, e.wd);
    end
    if (e.fl) check("flush_pc", ws_flush_pc, e.fpc);
    if (e.v) check("wb_pc", debug_wb_pc, e.pc);
  endtask

  task automatic step(input bit rst, input bit v, input logic [151:0] b, input exp_t e);
    @(negedge clk);
    if (sb.size() > 0) compare_head();
    reset          = rst;
    ms_to_ws_valid = v;
    ms_to_ws_bus   = b;
    sb.push_back(e);
  endtask

  task automatic alu(input logic [4:0] d, input logic [31:0] res, input logic [31:0] pc);
    step(0, 1, mk('0, 0, 0, 0, 0, '0, '0, 1, d, res, pc), ex(1, 1, d, res, 0, '0, pc));
  endtask

  task automatic csrwr(input logic [13:0] num, input logic [31:0] val, input logic [31:0] mask,
                       input logic [31:0] pc);
    step(0, 1, mk(val, 0, 0, 0, 1, num, mask, 0, 5'd0, '0, pc), ex(1, 0, '0, '0, 0, '0, pc));
  endtask

  task automatic csrrd(input logic [13:0] num, input logic [4:0] d, input logic [31:0] expv,
                       input logic [31:0] pc);
    step(0, 1, mk('0, 0, 0, 1, 0, num, '0, 1, d, 32'hDEAD_BEEF, pc), ex(1, 1, d, expv, 0, '0, pc));
  endtask

  task automatic sysc(input logic [31:0] pc, input logic [31:0] target);
    step(0, 1, mk('0, 0, 1, 0, 0, '0, '0, 1, 5'd7, 32'h1111, pc), ex(1, 0, '0, '0, 1, target, pc));
  endtask

  task automatic ertn_i(input logic [31:0] pc, input logic [31:0] target, input logic we,
                        input logic [31:0] wv, input logic [31:0] mask);
    step(0, 1, mk(wv, 1, 0, 0, we, 14'h00, mask, 1, 5'd7, 32'h2222, pc),
         ex(1, 0, '0, '0, 1, target, pc));
  endtask

  task automatic bubble();
    logic [151:0] junk;
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
    step(0, 0, junk, ex(0, 0, '0, '0, 0, '0, '0));
  endtask

  task automatic rst_cycle(input bit v);
    step(1, v, mk('0, 0, 0, 0, 0, '0, '0, 1, 5'd9, 32'h9999, 32'h1C00_0F00),
         ex(0, 0, '0, '0, 0, '0, '0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;

    rst_cycle(0);
    rst_cycle(1);
    rst_cycle(0);

    alu(5'd5, 32'h0000_1234, 32'h1C00_0000);

    csrwr(14'h30, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h1C00_0004);
    csrrd(14'h30, 5'd4, 32'hA5A5_A5A5, 32'h1C00_0008);

    csrwr(14'h0C, 32'h1C00_8000, 32'hFFFF_FFFF, 32'h1C00_000C);
    sysc(32'h1C00_0100, 32'h1C00_8000);
    csrrd(14'h06, 5'd6, 32'h1C00_0100, 32'h1C00_8000);
    csrrd(14'h05, 5'd6, 32'h000B_0000, 32'h1C00_8004);
    csrrd(14'h00, 5'd6, 32'h0000_0008, 32'h1C00_8008);
    csrrd(14'h01, 5'd6, 32'h0000_0000, 32'h1C00_800C);

    csrwr(14'h00, 32'h0000_0007, 32'hFFFF_FFFF, 32'h1C00_0110);
    sysc(32'h1C00_0200, 32'h1C00_8000);
    csrrd(14'h00, 5'd8, 32'h0000_0000, 32'h1C00_8000);
    csrrd(14'h01, 5'd8, 32'h0000_0007, 32'h1C00_8004);
    ertn_i(32'h1C00_8010, 32'h1C00_0200, 1, 32'h0, 32'hF);
    csrrd(14'h00, 5'd8, 32'h0000_0007, 32'h1C00_0200);

    csrwr(14'h00, 32'h0000_0008, 32'hFFFF_FFFF, 32'h1C00_0204);
    csrwr(14'h00, 32'h0000_00FF, 32'h0000_0003, 32'h1C00_0208);
    csrrd(14'h00, 5'd9, 32'h0000_000B, 32'h1C00_020C);
    csrrd(14'h7FF, 5'd9, 32'h0000_0000, 32'h1C00_0210);
    csrwr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1C00_0214);
    csrrd(14'h05, 5'd9, 32'h7FFF_0000, 32'h1C00_0218);

    alu(5'd1, 32'h0000_0001, 32'h1C00_0300);
    bubble();
    alu(5'd2, 32'h0000_0002, 32'h1C00_0304);
    alu(5'd0, 32'h0000_0003, 32'h1C00_0308);
    bubble();
    bubble();
    alu(5'd31, 32'hFFFF_FFFF, 32'h1C00_030C);

    csrwr(14'h30, 32'h0000_5555, 32'hFFFF_FFFF, 32'h1C00_0400);
    rst_cycle(1);
    csrrd(14'h30, 5'd3, 32'h0000_0000, 32'h1C00_0000);
    csrrd(14'h00, 5'd3, 32'h0000_0008, 32'h1C00_0004);
    csrrd(14'h06, 5'd3, 32'h0000_0000, 32'h1C00_0008);
    bubble();

    @(negedge clk);
    compare_head();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
